hazard_ctrl_mc: RTL and testbench

- Parametrised successor to the pipeline hazard controller for the five-stage RV64 pipeline (fetch -> regD -> decode -> regE -> execute -> regM -> memory -> regW -> writeback).
- Generates per-stage stall and flush for load-use, branch/jump redirect, multi-cycle execute ops (mul/div), memory wait-states with timeout, and writeback traps.
- Holds a small FSM plus timeout and performance counters; pipeline registers consume its outputs in the same cycle.

---
 rtl/hazard_ctrl_mc_pkg.sv | 19 +
 rtl/hazard_detect.sv | 22 ++
 rtl/hazard_ctrl_mc.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared types for the multi-cycle pipeline hazard controller: FSM states and
// pipeline stage indices used to address the stall/flush vectors.
package hazard_ctrl_mc_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    MEM_WAIT = 2'd2,
    TRAP     = 2'd3
  } state_e;

  // Stall vectors span F..M (regW is never stalled); flush vectors span D..W.
  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in execute whose destination is read by the
// instruction in decode. Register x0 never creates a hazard.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic              mem_ren,
  input  logic [REG_AW-1:0] rd,
  output logic              load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = rs1_used & (rs1 == rd);
  assign rs2_hit  = rs2_used & (rs2 == rd);
  assign load_use = mem_ren & (rd != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller with multi-cycle execute and memory wait-state
// support; stall/flush outputs are combinational so registers act the same cycle.
module hazard_ctrl_mc
  import hazard_ctrl_mc_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 7,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] decode_i_rs1,
  input  logic [REG_AW-1:0] decode_i_rs2,
  input  logic              decode_i_rs1_used,
  input  logic              decode_i_rs2_used,
  input  logic              regE_i_mem_ren,
  input  logic [REG_AW-1:0] regE_i_rd,
  input  logic              execute_i_need_jump,
  input  logic              execute_i_mc_start,
  input  logic              execute_i_mc_done,
  input  logic              memory_i_req,
  input  logic              memory_i_ack,
  input  logic              wb_i_trap,
  output logic              ctrl_o_regF_stall,
  output logic              ctrl_o_regD_stall,
  output logic              ctrl_o_regE_stall,
  output logic              ctrl_o_regM_stall,
  output logic              ctrl_o_regD_flush,
  output logic              ctrl_o_regE_flush,
  output logic              ctrl_o_regM_flush,
  output logic              ctrl_o_regW_flush,
  output logic              ctrl_o_mem_timeout,
  output logic [CNT_W-1:0]  ctrl_o_stall_cnt
);

  state_e             state;
  state_e             state_nxt;
  logic [TO_W-1:0]    to_cnt;
  logic [TO_W-1:0]    to_nxt;
  logic [CNT_W-1:0]   stall_cnt;
  logic [STG_M:STG_F] stall_v;
  logic [STG_W:STG_D] flush_v;
  logic               timeout;
  logic               load_use;
  logic               mem_block;
  logic               mc_block;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_detect (
    .rs1      (decode_i_rs1),
    .rs2      (decode_i_rs2),
    .rs1_used (decode_i_rs1_used),
    .rs2_used (decode_i_rs2_used),
    .mem_ren  (regE_i_mem_ren),
    .rd       (regE_i_rd),
    .load_use (load_use)
  );

  // A request acked (or an op finished) in its own issue cycle costs nothing.
  assign mem_block = memory_i_req & ~memory_i_ack;
  assign mc_block  = execute_i_mc_start & ~execute_i_mc_done;

  always_comb begin
    state_nxt = state;
    to_nxt    = to_cnt;
    stall_v   = '0;
    flush_v   = '0;
    timeout   = 1'b0;
    unique case (state)
      RUN: begin
        if (wb_i_trap) begin
          flush_v   = '1;
          state_nxt = TRAP;
        end else if (mem_block) begin
          stall_v        = '1;
          flush_v[STG_W] = 1'b1;
          state_nxt      = MEM_WAIT;
          to_nxt         = TO_W'(1);
        end else if (mc_block) begin
          stall_v[STG_E:STG_F] = '1;
          flush_v[STG_M]       = 1'b1;
          state_nxt            = MC_WAIT;
        end else if (execute_i_need_jump) begin
          flush_v[STG_E:STG_D] = '1;
        end else if (load_use) begin
          stall_v[STG_D:STG_F] = '1;
          flush_v[STG_E]       = 1'b1;
        end
      end
      MC_WAIT: begin
        if (wb_i_trap) begin
          flush_v   = '1;
          state_nxt = TRAP;
        end else if (execute_i_mc_done) begin
          state_nxt = RUN;
        end else begin
          stall_v[STG_E:STG_F] = '1;
          flush_v[STG_M]       = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Ack is checked before the timeout so a last-moment ack still wins.
        if (wb_i_trap) begin
          flush_v   = '1;
          state_nxt = TRAP;
          to_nxt    = '0;
        end else if (memory_i_ack) begin
          state_nxt = RUN;
          to_nxt    = '0;
        end else if (to_cnt == TO_W'(MEM_TIMEOUT)) begin
          timeout   = 1'b1;
          flush_v   = '1;
          state_nxt = TRAP;
          to_nxt    = '0;
        end else begin
          stall_v        = '1;
          flush_v[STG_W] = 1'b1;
          to_nxt         = to_cnt + TO_W'(1);
        end
      end
      TRAP: begin
        flush_v   = '1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      to_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_nxt;
      if (stall_v[STG_F] && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  // Outputs are forced low while reset is held, independent of the clock.
  assign ctrl_o_regF_stall  = stall_v[STG_F] & ~rst;
  assign ctrl_o_regD_stall  = stall_v[STG_D] & ~rst;
  assign ctrl_o_regE_stall  = stall_v[STG_E] & ~rst;
  assign ctrl_o_regM_stall  = stall_v[STG_M] & ~rst;
  assign ctrl_o_regD_flush  = flush_v[STG_D] & ~rst;
  assign ctrl_o_regE_flush  = flush_v[STG_E] & ~rst;
  assign ctrl_o_regM_flush  = flush_v[STG_M] & ~rst;
  assign ctrl_o_regW_flush  = flush_v[STG_W] & ~rst;
  assign ctrl_o_mem_timeout = timeout & ~rst;
  assign ctrl_o_stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench for hazard_ctrl_mc: a vector table, directed multi-cycle
// sequences, and randomized traffic against a behavioural reference model.
module tb_hazard_ctrl_mc;

  localparam int REG_AW      = 5;
  localparam int MEM_TIMEOUT = 4;
  localparam int TO_W        = 4;
  localparam int CNT_W       = 6;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       mem_ren;
    logic [4:0] rd;
    logic       jump;
    logic       mc_start;
    logic       mc_done;
    logic       req;
    logic       ack;
    logic       trap;
  } ins_t;

  // Field order: F D E M stall, D E M W flush, timeout.
  typedef struct packed {
    logic f_st, d_st, e_st, m_st;
    logic d_fl, e_fl, m_fl, w_fl;
    logic to;
  } outs_t;

  typedef struct {
    ins_t  in;
    outs_t exp;
  } vec_t;

  localparam outs_t O_NONE = 9'b0000_0000_0;
  localparam outs_t O_LU   = 9'b1100_0100_0;
  localparam outs_t O_JMP  = 9'b0000_1100_0;
  localparam outs_t O_MC   = 9'b1110_0010_0;
  localparam outs_t O_MEM  = 9'b1111_0001_0;
  localparam outs_t O_TRAP = 9'b0000_1111_0;
  localparam outs_t O_TO   = 9'b0000_1111_1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [REG_AW-1:0] decode_i_rs1, decode_i_rs2, regE_i_rd;
  logic              decode_i_rs1_used, decode_i_rs2_used, regE_i_mem_ren;
  logic              execute_i_need_jump, execute_i_mc_start, execute_i_mc_done;
  logic              memory_i_req, memory_i_ack, wb_i_trap;
  logic              ctrl_o_regF_stall, ctrl_o_regD_stall, ctrl_o_regE_stall, ctrl_o_regM_stall;
  logic              ctrl_o_regD_flush, ctrl_o_regE_flush, ctrl_o_regM_flush, ctrl_o_regW_flush;
  logic              ctrl_o_mem_timeout;
  logic [CNT_W-1:0]  ctrl_o_stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int tally  = 0;

  bit m_trap_pend;
  bit m_mc;
  int m_mem;

  vec_t vecs[10];

  hazard_ctrl_mc #(
    .REG_AW(REG_AW), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .decode_i_rs1(decode_i_rs1), .decode_i_rs2(decode_i_rs2),
    .decode_i_rs1_used(decode_i_rs1_used), .decode_i_rs2_used(decode_i_rs2_used),
    .regE_i_mem_ren(regE_i_mem_ren), .regE_i_rd(regE_i_rd),
    .execute_i_need_jump(execute_i_need_jump),
    .execute_i_mc_start(execute_i_mc_start), .execute_i_mc_done(execute_i_mc_done),
    .memory_i_req(memory_i_req), .memory_i_ack(memory_i_ack), .wb_i_trap(wb_i_trap),
    .ctrl_o_regF_stall(ctrl_o_regF_stall), .ctrl_o_regD_stall(ctrl_o_regD_stall),
    .ctrl_o_regE_stall(ctrl_o_regE_stall), .ctrl_o_regM_stall(ctrl_o_regM_stall),
    .ctrl_o_regD_flush(ctrl_o_regD_flush), .ctrl_o_regE_flush(ctrl_o_regE_flush),
    .ctrl_o_regM_flush(ctrl_o_regM_flush), .ctrl_o_regW_flush(ctrl_o_regW_flush),
    .ctrl_o_mem_timeout(ctrl_o_mem_timeout), .ctrl_o_stall_cnt(ctrl_o_stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic ins_t lu(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic ren, logic [4:0] rd);
    ins_t v;
    v          = '0;
    v.rs1      = rs1;
    v.rs2      = rs2;
    v.rs1_used = u1;
    v.rs2_used = u2;
    v.mem_ren  = ren;
    v.rd       = rd;
    return v;
  endfunction

  function automatic outs_t sample();
    return {ctrl_o_regF_stall, ctrl_o_regD_stall, ctrl_o_regE_stall, ctrl_o_regM_stall,
            ctrl_o_regD_flush, ctrl_o_regE_flush, ctrl_o_regM_flush, ctrl_o_regW_flush,
            ctrl_o_mem_timeout};
  endfunction

  task automatic applyStimulus(input ins_t v);
    decode_i_rs1        = v.rs1;
    decode_i_rs2        = v.rs2;
    decode_i_rs1_used   = v.rs1_used;
    decode_i_rs2_used   = v.rs2_used;
    regE_i_mem_ren      = v.mem_ren;
    regE_i_rd           = v.rd;
    execute_i_need_jump = v.jump;
    execute_i_mc_start  = v.mc_start;
    execute_i_mc_done   = v.mc_done;
    memory_i_req        = v.req;
    memory_i_ack        = v.ack;
    wb_i_trap           = v.trap;
  endtask

  task automatic checkOutput(input string name, input outs_t exp, input int exp_cnt);
    outs_t act;
    act = sample();
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s outputs: got %b, want %b (FDEM stall|DEMW flush|timeout)",
               name, act, exp);
    end
    n_cmp++;
    if (ctrl_o_stall_cnt !== CNT_W'(exp_cnt)) begin
      n_fail++;
      $display("[TB] FAIL %s stall_cnt: got %0d, want %0d", name, ctrl_o_stall_cnt, exp_cnt);
    end
  endtask

  // One clock cycle: drive after the edge, check mid-cycle, then advance.
  task automatic cycle(input string name, input ins_t v, input outs_t exp);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(name, exp, tally);
    if (exp.f_st && tally != CNT_MAX) tally++;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus('0);
    tally       = 0;
    m_trap_pend = 1'b0;
    m_mc        = 1'b0;
    m_mem       = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model: tracks "in a multi-cycle op", "cycles spent waiting on
  // memory" and "trap flush owed next cycle", and applies the priority rules.
  task automatic model_step(input ins_t v, output outs_t e);
    bit hz;
    e  = O_NONE;
    hz = v.mem_ren && (v.rd != 5'd0) &&
         ((v.rs1_used && v.rs1 == v.rd) || (v.rs2_used && v.rs2 == v.rd));
    if (m_trap_pend) begin
      e           = O_TRAP;
      m_trap_pend = 1'b0;
    end else if (m_mem > 0) begin
      if (v.trap) begin
        e = O_TRAP; m_trap_pend = 1'b1; m_mem = 0;
      end else if (v.ack) begin
        m_mem = 0;
      end else if (m_mem == MEM_TIMEOUT) begin
        e = O_TO; m_trap_pend = 1'b1; m_mem = 0;
      end else begin
        e = O_MEM; m_mem++;
      end
    end else if (m_mc) begin
      if (v.trap) begin
        e = O_TRAP; m_trap_pend = 1'b1; m_mc = 1'b0;
      end else if (v.mc_done) begin
        m_mc = 1'b0;
      end else begin
        e = O_MC;
      end
    end else begin
      if (v.trap) begin
        e = O_TRAP; m_trap_pend = 1'b1;
      end else if (v.req && !v.ack) begin
        e = O_MEM; m_mem = 1;
      end else if (v.mc_start && !v.mc_done) begin
        e = O_MC; m_mc = 1'b1;
      end else if (v.jump) begin
        e = O_JMP;
      end else if (hz) begin
        e = O_LU;
      end
    end
  endtask

  initial begin
    ins_t  v;
    outs_t e;

    vecs[0].in = lu(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5); vecs[0].exp = O_LU;
    vecs[1].in = lu(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0); vecs[1].exp = O_NONE;
    vecs[2].in = lu(5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7); vecs[2].exp = O_LU;
    vecs[3].in = lu(5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9); vecs[3].exp = O_NONE;
    vecs[4].in = lu(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd4); vecs[4].exp = O_NONE;
    vecs[5].in = lu(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5); vecs[5].in.jump = 1'b1;
    vecs[5].exp = O_JMP;
    vecs[6].in = '0; vecs[6].in.req = 1'b1; vecs[6].in.ack = 1'b1; vecs[6].exp = O_NONE;
    vecs[7].in = '0; vecs[7].in.mc_start = 1'b1; vecs[7].in.mc_done = 1'b1;
    vecs[7].exp = O_NONE;
    vecs[8].in = lu(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3); vecs[8].exp = O_LU;
    vecs[9].in = lu(5'd6, 5'd2, 1'b0, 1'b1, 1'b1, 5'd6); vecs[9].exp = O_NONE;

    $display("[TB] start");

    // Outputs held low while reset is asserted, even with a hazard present.
    applyStimulus(vecs[0].in);
    @(posedge clk);
    #1;
    checkOutput("reset_state", O_NONE, 0);
    doReset();

    for (int i = 0; i < 10; i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp);
    end

    // Multi-cycle op: start at 0, done at 4; jump/load-use ignored meanwhile.
    doReset();
    v = '0; v.mc_start = 1'b1;
    cycle("mc_c0", v, O_MC);
    v = '0;
    cycle("mc_c1", v, O_MC);
    v = vecs[0].in; v.jump = 1'b1;
    cycle("mc_c2_ignore", v, O_MC);
    v = '0;
    cycle("mc_c3", v, O_MC);
    v.mc_done = 1'b1;
    cycle("mc_c4_done", v, O_NONE);
    v = '0;
    cycle("mc_after", v, O_NONE);

    // Memory wait running into the timeout.
    doReset();
    v = '0; v.req = 1'b1;
    for (int i = 0; i < 4; i++) cycle($sformatf("memto_c%0d", i), v, O_MEM);
    cycle("memto_c4_timeout", v, O_TO);
    cycle("memto_c5_trap", v, O_TRAP);
    v = '0;
    cycle("memto_c6_run", v, O_NONE);

    // Ack arriving on the timeout cycle wins.
    doReset();
    v = '0; v.req = 1'b1;
    for (int i = 0; i < 4; i++) cycle($sformatf("memack_c%0d", i), v, O_MEM);
    v.ack = 1'b1;
    cycle("memack_c4_ack", v, O_NONE);
    v = '0;
    cycle("memack_c5", v, O_NONE);

    // Trap during a memory wait.
    doReset();
    v = '0; v.req = 1'b1;
    cycle("memtrap_c0", v, O_MEM);
    cycle("memtrap_c1", v, O_MEM);
    v.trap = 1'b1;
    cycle("memtrap_c2_trap", v, O_TRAP);
    v = '0;
    cycle("memtrap_c3_trapst", v, O_TRAP);
    cycle("memtrap_c4_run", v, O_NONE);

    // Trap during a multi-cycle wait.
    doReset();
    v = '0; v.mc_start = 1'b1;
    cycle("mctrap_c0", v, O_MC);
    v = '0; v.trap = 1'b1;
    cycle("mctrap_c1_trap", v, O_TRAP);
    v = '0;
    cycle("mctrap_c2_trapst", v, O_TRAP);
    cycle("mctrap_c3_run", v, O_NONE);

    // Asynchronous reset in the middle of a multi-cycle wait.
    doReset();
    v = '0; v.mc_start = 1'b1;
    cycle("rstmc_c0", v, O_MC);
    v = '0;
    cycle("rstmc_c1", v, O_MC);
    rst = 1'b1;
    #1;
    checkOutput("rstmc_async", O_NONE, 0);
    tally = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("rstmc_run", v, O_NONE);

    // Long multi-cycle op saturates the stall counter.
    doReset();
    v = '0; v.mc_start = 1'b1;
    cycle("sat_start", v, O_MC);
    v = '0;
    for (int i = 0; i < 69; i++) cycle($sformatf("sat_w%0d", i), v, O_MC);
    v.mc_done = 1'b1;
    cycle("sat_done", v, O_NONE);
    v = '0;
    cycle("sat_final", v, O_NONE);

    // Randomized traffic against the reference model.
    doReset();
    for (int n = 0; n < 2000; n++) begin
      if (n % 500 == 499) doReset();
      v          = '0;
      v.rs1      = 5'($urandom_range(0, 3));
      v.rs2      = 5'($urandom_range(0, 3));
      v.rd       = 5'($urandom_range(0, 3));
      v.rs1_used = 1'($urandom_range(0, 1));
      v.rs2_used = 1'($urandom_range(0, 1));
      v.mem_ren  = 1'($urandom_range(0, 1));
      v.jump     = ($urandom_range(0, 3) == 0);
      v.mc_start = ($urandom_range(0, 5) == 0);
      v.mc_done  = ($urandom_range(0, 3) == 0);
      v.req      = ($urandom_range(0, 5) == 0);
      v.ack      = ($urandom_range(0, 4) == 0);
      v.trap     = ($urandom_range(0, 24) == 0);
      model_step(v, e);
      cycle($sformatf("rand%0d", n), v, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
